// File: rtl/icb_sram_rsp.sv
// rtl/icb_sram_rsp.sv - ICB slave responder backed by a word-addressed on-chip SRAM
//
// Accepts ICB read/write commands into a one-entry stage (S1), performs the
// SRAM access, and returns in-order {rdata, err} responses through a small FIFO.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   icb_cmd_valid/ready    command handshake
//   icb_cmd_addr           byte address
//   icb_cmd_read           1 = read, 0 = write
//   icb_cmd_wdata/wmask    write data and byte enables
//   icb_rsp_valid/ready    response handshake
//   icb_rsp_rdata/err      response payload, gated to 0 while rsp_valid is low
module icb_sram_rsp #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          RSP_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icb_cmd_valid,
    output logic        icb_cmd_ready,
    input  logic [31:0] icb_cmd_addr,
    input  logic        icb_cmd_read,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [3:0]  icb_cmd_wmask,
    output logic        icb_rsp_valid,
    input  logic        icb_rsp_ready,
    output logic [31:0] icb_rsp_rdata,
    output logic        icb_rsp_err
);

    localparam int              PTR_W   = $clog2(RSP_DEPTH);
    localparam int              OCC_W   = PTR_W + 1;
    localparam int              WORDS   = 1 << DEPTH_LOG2;
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(RSP_DEPTH);

    logic [31:0]           r_mem [WORDS];
    logic [31:0]           r_fifo_rdata [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  r_fifo_err;
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [OCC_W-1:0]      r_occ;
    logic                  r_s1_valid;
    logic                  r_s1_err;
    logic                  r_s1_read;
    logic [DEPTH_LOG2-1:0] r_s1_idx;

    logic                  w_cmd_ready;
    logic                  w_accept;
    logic [OCC_W-1:0]      w_fifo_cnt;
    logic                  w_rsp_valid;
    logic                  w_pop;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_s1_rdata;

    // occ covers the S1 entry plus stored entries, so ready depends only on
    // registered state and the FIFO can never be overrun.
    assign w_cmd_ready = (r_occ < OCC_MAX);
    assign w_accept    = icb_cmd_valid && w_cmd_ready;
    assign w_fifo_cnt  = r_occ - {{PTR_W{1'b0}}, r_s1_valid};
    assign w_rsp_valid = (w_fifo_cnt != '0);
    assign w_pop       = w_rsp_valid && icb_rsp_ready;

    // BASE_ADDR is aligned to the window size, so a range check reduces to
    // comparing the bits above the word index.
    assign w_in_range = (icb_cmd_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2])
                     && (icb_cmd_addr[1:0] == 2'b00);
    assign w_idx      = icb_cmd_addr[DEPTH_LOG2+1:2];

    // Writes land on the accept edge, one cycle before any later read reaches
    // this point, so read-after-write needs no bypass.
    assign w_s1_rdata = (r_s1_read && !r_s1_err) ? r_mem[r_s1_idx] : 32'h0;

    // SRAM array: never reset, contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_accept && !icb_cmd_read && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (icb_cmd_wmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response FIFO payload storage; validity is tracked by the pointers/occ.
    always_ff @(posedge clk) begin
        if (r_s1_valid) begin
            r_fifo_rdata[r_wptr] <= w_s1_rdata;
            r_fifo_err[r_wptr]   <= r_s1_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_read  <= 1'b0;
            r_s1_idx   <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_err  <= !w_in_range;
                r_s1_read <= icb_cmd_read;
                r_s1_idx  <= w_idx;
            end
            if (r_s1_valid) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign icb_cmd_ready = w_cmd_ready;
    assign icb_rsp_valid = w_rsp_valid;
    assign icb_rsp_rdata = w_rsp_valid ? r_fifo_rdata[r_rptr] : 32'h0;
    assign icb_rsp_err   = w_rsp_valid ? r_fifo_err[r_rptr]   : 1'b0;

endmodule

// File: tb/tb_icb_sram_rsp.sv
// tb/tb_icb_sram_rsp.sv - directed self-checking bench for icb_sram_rsp
module tb_icb_sram_rsp;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icb_cmd_valid = 1'b0;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr = 32'h0;
    logic        icb_cmd_read = 1'b0;
    logic [31:0] icb_cmd_wdata = 32'h0;
    logic [3:0]  icb_cmd_wmask = 4'h0;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready = 1'b1;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] erd;
        logic        eerr;
    } cmd_t;

    cmd_t q[$];
    cmd_t bp[6];

    always #5 clk = ~clk;

    icb_sram_rsp #(
        .BASE_ADDR (BASE),
        .DEPTH_LOG2(10),
        .RSP_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .icb_cmd_valid(icb_cmd_valid),
        .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr (icb_cmd_addr),
        .icb_cmd_read (icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata),
        .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid),
        .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata),
        .icb_rsp_err  (icb_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input logic [31:0] erd, input logic eerr);
        cmd_t c;
        c.rd = rd; c.addr = addr; c.wdata = wdata; c.wmask = wmask; c.erd = erd; c.eerr = eerr;
        q.push_back(c);
    endtask

    task automatic drive(input cmd_t c);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = c.rd;
        icb_cmd_addr  = c.addr;
        icb_cmd_wdata = c.wdata;
        icb_cmd_wmask = c.wmask;
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] erd, input logic eerr);
        chk({tag, ".valid"}, 32'(icb_rsp_valid), 32'd1);
        chk({tag, ".rdata"}, icb_rsp_rdata, erd);
        chk({tag, ".err"}, 32'(icb_rsp_err), 32'(eerr));
    endtask

    // Issues the queued commands back-to-back with rsp_ready high; each
    // response must appear exactly one edge after its accept edge.
    task automatic run_stream(input string tag);
        int n;
        n = q.size();
        icb_rsp_ready = 1'b1;
        for (int k = 0; k <= n; k++) begin
            if (k < n) begin
                drive(q[k]);
                chk($sformatf("%s.cmd_ready[%0d]", tag, k), 32'(icb_cmd_ready), 32'd1);
            end else begin
                icb_cmd_valid = 1'b0;
            end
            tick();
            if (k == 0) begin
                chk($sformatf("%s.lat0", tag), 32'(icb_rsp_valid), 32'd0);
            end else begin
                chk_rsp($sformatf("%s.rsp[%0d]", tag, k - 1), q[k-1].erd, q[k-1].eerr);
            end
        end
        tick();
        chk({tag, ".drained"}, 32'(icb_rsp_valid), 32'd0);
        q.delete();
    endtask

    function automatic logic [31:0] sdata(input int k);
        return (32'(k) * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
    endfunction

    initial begin
        // Reset state
        tick();
        chk("rst.cmd_ready", 32'(icb_cmd_ready), 32'd1);
        chk("rst.rsp_valid", 32'(icb_rsp_valid), 32'd0);
        chk("rst.rsp_rdata", icb_rsp_rdata, 32'h0);
        chk("rst.rsp_err", 32'(icb_rsp_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle.rsp_valid", 32'(icb_rsp_valid), 32'd0);

        // Write then read
        push(1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        run_stream("wr1");
        push(1'b1, BASE + 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        run_stream("rd1");

        // Byte masks, back-to-back RAW, empty mask
        push(1'b0, BASE + 32'h20, 32'h1122_3344, 4'hF,    32'h0, 1'b0);
        push(1'b0, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
        push(1'b1, BASE + 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
        push(1'b0, BASE + 32'h20, 32'hCAFE_F00D, 4'hF,    32'h0, 1'b0);
        push(1'b1, BASE + 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
        push(1'b0, BASE + 32'h20, 32'hFFFF_FFFF, 4'h0,    32'h0, 1'b0);
        push(1'b1, BASE + 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
        run_stream("mask");

        // Errors and window boundaries
        push(1'b1, BASE + 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);
        push(1'b1, BASE - 32'h4,    32'h0, 4'h0, 32'h0, 1'b1);
        push(1'b0, BASE + 32'h0,    32'h0102_0304, 4'hF, 32'h0, 1'b0);
        push(1'b0, BASE + 32'h2,    32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        push(1'b1, BASE + 32'h0,    32'h0, 4'h0, 32'h0102_0304, 1'b0);
        push(1'b0, BASE + 32'hFFC,  32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
        push(1'b1, BASE + 32'hFFC,  32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
        push(1'b0, BASE + 32'h1000, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
        run_stream("err");

        // Backpressure: 6 reads with rsp_ready low, only 4 accepted
        bp[0] = '{1'b1, BASE + 32'h10,   32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};
        bp[1] = '{1'b1, BASE + 32'h20,   32'h0, 4'h0, 32'hCAFE_F00D, 1'b0};
        bp[2] = '{1'b1, BASE + 32'h0,    32'h0, 4'h0, 32'h0102_0304, 1'b0};
        bp[3] = '{1'b1, BASE + 32'hFFC,  32'h0, 4'h0, 32'h0BAD_F00D, 1'b0};
        bp[4] = '{1'b1, BASE + 32'h10,   32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};
        bp[5] = '{1'b1, BASE + 32'h1000, 32'h0, 4'h0, 32'h0,         1'b1};
        icb_rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(bp[k]);
            chk($sformatf("bp.accept_ready[%0d]", k), 32'(icb_cmd_ready), 32'd1);
            tick();
        end
        chk("bp.full_ready", 32'(icb_cmd_ready), 32'd0);
        drive(bp[4]);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp.stall_ready[%0d]", k), 32'(icb_cmd_ready), 32'd0);
            chk_rsp($sformatf("bp.stable[%0d]", k), bp[0].erd, bp[0].eerr);
            tick();
        end
        icb_rsp_ready = 1'b1;
        tick();                                  // pops bp0, bp4 not yet accepted
        chk("bp.recover_ready", 32'(icb_cmd_ready), 32'd1);
        chk_rsp("bp.rsp1", bp[1].erd, bp[1].eerr);
        tick();                                  // accepts bp4, pops bp1
        chk("bp.ready_after4", 32'(icb_cmd_ready), 32'd1);
        chk_rsp("bp.rsp2", bp[2].erd, bp[2].eerr);
        drive(bp[5]);
        tick();                                  // accepts bp5, pops bp2
        icb_cmd_valid = 1'b0;
        chk_rsp("bp.rsp3", bp[3].erd, bp[3].eerr);
        tick();
        chk_rsp("bp.rsp4", bp[4].erd, bp[4].eerr);
        tick();
        chk_rsp("bp.rsp5", bp[5].erd, bp[5].eerr);
        tick();
        chk("bp.drained", 32'(icb_rsp_valid), 32'd0);

        // Streaming: 64 writes followed by 64 reads, one per cycle
        for (int k = 0; k < 64; k++)
            push(1'b0, BASE + 32'h100 + 32'(4 * k), sdata(k), 4'hF, 32'h0, 1'b0);
        for (int k = 0; k < 64; k++)
            push(1'b1, BASE + 32'h100 + 32'(4 * k), 32'h0, 4'h0, sdata(k), 1'b0);
        run_stream("stream");

        // Reset with 3 responses pending
        icb_rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(bp[k]);
            tick();
        end
        icb_cmd_valid = 1'b0;
        chk_rsp("rstmid.pending", bp[0].erd, bp[0].eerr);
        rst_n = 1'b0;
        #1;
        chk("rstmid.rsp_valid", 32'(icb_rsp_valid), 32'd0);
        chk("rstmid.cmd_ready", 32'(icb_cmd_ready), 32'd1);
        chk("rstmid.rdata", icb_rsp_rdata, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        icb_rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rstmid.no_stale[%0d]", k), 32'(icb_rsp_valid), 32'd0);
        end
        push(1'b1, BASE + 32'h10,  32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        push(1'b1, BASE + 32'h100, 32'h0, 4'h0, sdata(0), 1'b0);
        push(1'b1, BASE + 32'h1FC, 32'h0, 4'h0, sdata(63), 1'b0);
        run_stream("retain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
